// File: rtl/controle_rodadas_pkg.sv
// Shared state codes for the round sequencer. The top level and the
// display bench use the same 4-bit values for db_estado.
package controle_rodadas_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

endpackage

// File: rtl/controle_rodadas_timeout.sv
// Play timeout counter: synchronous clear and enable, saturates at the
// terminal count so it can never wrap while the owner is still waiting.
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TW             = $clog2(TIMEOUT_CICLOS)
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [TW-1:0] valor;

  assign fim = (valor == TW'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (conta && !fim) begin
      valor <= valor + 1'b1;
    end
  end

endmodule

// File: rtl/controle_rodadas.sv
// Round-based Moore sequencer for the sequence-memory game: drives the
// E/L/R datapath controls and owns the per-play timeout.
module controle_rodadas
  import controle_rodadas_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TW             = $clog2(TIMEOUT_CICLOS)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       botoesIgualMemoria,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado, proximo;
  logic    fim_timer;

  // Timer only runs in espera; every other state clears it for a fresh window.
  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
    .TW            (TW)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .zera (estado != ESPERA),
    .conta(estado == ESPERA),
    .fim  (fim_timer)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     proximo = INICIA_RODADA;
      INICIA_RODADA:  proximo = ESPERA;
      // A play in the last timer cycle takes priority over the timeout.
      ESPERA:         proximo = jogada    ? REGISTRA :
                                fim_timer ? FIM_TIMEOUT : ESPERA;
      REGISTRA:       proximo = COMPARA;
      COMPARA: begin
        if (!botoesIgualMemoria)       proximo = FIM_ERRO;
        else if (!enderecoIgualLimite) proximo = PROXIMA_JOGADA;
        else if (fimL)                 proximo = FIM_ACERTO;
        else                           proximo = PROXIMA_RODADA;
      end
      PROXIMA_JOGADA: proximo = ESPERA;
      PROXIMA_RODADA: proximo = INICIA_RODADA;
      FIM_ACERTO:     proximo = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:       proximo = iniciar ? PREPARACAO : FIM_ERRO;
      FIM_TIMEOUT:    proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:        proximo = INICIAL;
    endcase
  end

  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    pronto    = 1'b0;
    timeout   = 1'b0;
    case (estado)
      PREPARACAO: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      INICIA_RODADA:  zeraE     = 1'b1;
      REGISTRA:       registraR = 1'b1;
      PROXIMA_JOGADA: contaE    = 1'b1;
      PROXIMA_RODADA: contaL    = 1'b1;
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_controle_rodadas.sv
// Bench for controle_rodadas: directed cycle-by-cycle vectors with the
// expected state and outputs queued for a separate monitor.
module tb_controle_rodadas;
  import controle_rodadas_pkg::*;

  localparam int W = 14;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0, jogada = 1'b0;
  logic       botoesIgualMemoria = 1'b0, enderecoIgualLimite = 1'b0, fimL = 1'b0;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       acertou, errou, pronto, timeout;
  logic [3:0] db_estado;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         amostra_req = 1'b0;
  int           total = 0;
  int           bad = 0;
  int           conta_l_vistos = 0;

  controle_rodadas #(.TIMEOUT_CICLOS(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .botoesIgualMemoria(botoesIgualMemoria),
    .enderecoIgualLimite(enderecoIgualLimite), .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .acertou(acertou),
    .errou(errou), .pronto(pronto), .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Expected outputs per state, taken from the state/output table.
  // Order: zeraE contaE zeraL contaL zeraR registraR acertou errou pronto timeout
  function automatic logic [9:0] saidas(input logic [3:0] st);
    case (st)
      4'h1:    return 10'b1010100000;
      4'h2:    return 10'b1000000000;
      4'h4:    return 10'b0000010000;
      4'h6:    return 10'b0100000000;
      4'h7:    return 10'b0001000000;
      4'hA:    return 10'b0000001010;
      4'hE:    return 10'b0000000110;
      4'hD:    return 10'b0000000111;
      default: return 10'b0000000000;
    endcase
  endfunction

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, want);
    end
  endtask

  // One clock of stimulus; exp_st is the state expected after the next edge.
  task automatic step(input logic ini, input logic jog, input logic ig,
                      input logic eil, input logic fl,
                      input logic [3:0] exp_st, input string nm);
    @(negedge clock);
    iniciar             = ini;
    jogada              = jog;
    botoesIgualMemoria  = ig;
    enderecoIgualLimite = eil;
    fimL                = fl;
    exp_q.push_back({exp_st, saidas(exp_st)});
    name_q.push_back(nm);
  endtask

  task automatic jogar(input logic ig, input logic eil, input logic fl,
                       input logic [3:0] decisao);
    step(0, 1, 0, 0, 0, REGISTRA, "registra");
    step(0, 0, 0, 0, 0, COMPARA, "compara");
    step(0, 0, ig, eil, fl, decisao, "decisao");
  endtask

  // Reset raised between edges and checked before any clock edge arrives.
  task automatic reset_async(input string nm, input bit hold);
    @(negedge clock);
    iniciar = 0; jogada = 0; botoesIgualMemoria = 0;
    enderecoIgualLimite = 0; fimL = 0;
    reset = 1'b1;
    exp_q.push_back({INICIAL, saidas(INICIAL)});
    name_q.push_back(nm);
    amostra_req = 1'b1;
    #2;
    amostra_req = 1'b0;
    if (hold) begin
      exp_q.push_back({INICIAL, saidas(INICIAL)});
      name_q.push_back({nm, " held"});
      @(posedge clock);
      #2;
    end
    reset = 1'b0;
  endtask

  task automatic iniciar_jogo(input string nm);
    step(1, 0, 0, 0, 0, PREPARACAO, nm);
    step(0, 0, 0, 0, 0, INICIA_RODADA, nm);
    step(0, 0, 0, 0, 0, ESPERA, nm);
  endtask

  // Monitor: compares the DUT against the head of the queue after each edge.
  initial begin
    logic [W-1:0] exp_v, got_v;
    string        nm;
    forever begin
      @(posedge clock or posedge amostra_req);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        got_v = {db_estado, zeraE, contaE, zeraL, contaL, zeraR, registraR,
                 acertou, errou, pronto, timeout};
        total++;
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL %s: got estado=%h saidas=%b want estado=%h saidas=%b",
                   nm, got_v[13:10], got_v[9:0], exp_v[13:10], exp_v[9:0]);
        end
        if (contaL === 1'b1) conta_l_vistos++;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clock);
    reset_async("reset inicial", 1'b0);
    step(0, 0, 0, 0, 0, INICIAL, "ocioso");

    // Full game: rounds 0..3, last round flagged by fimL.
    iniciar_jogo("inicio acerto");
    for (int n = 0; n < 4; n++) begin
      for (int e = 0; e <= n; e++) begin
        if (e < n) begin
          jogar(1, 0, 0, PROXIMA_JOGADA);
          step(0, 0, 0, 0, 0, ESPERA, "volta espera");
        end else if (n < 3) begin
          jogar(1, 1, 0, PROXIMA_RODADA);
          step(0, 0, 0, 0, 0, INICIA_RODADA, "nova rodada");
          step(0, 0, 0, 0, 0, ESPERA, "espera rodada");
        end else begin
          jogar(1, 1, 1, FIM_ACERTO);
        end
      end
    end
    step(0, 0, 0, 0, 0, FIM_ACERTO, "mantem acerto");
    @(posedge clock);
    #2;
    check("pulsos contaL", conta_l_vistos, 3);

    // Wrong second play in round 1.
    iniciar_jogo("inicio erro");
    jogar(1, 1, 0, PROXIMA_RODADA);
    step(0, 0, 0, 0, 0, INICIA_RODADA, "rodada 1");
    step(0, 0, 0, 0, 0, ESPERA, "espera r1");
    jogar(1, 0, 0, PROXIMA_JOGADA);
    step(0, 0, 0, 0, 0, ESPERA, "espera r1 j1");
    jogar(0, 1, 0, FIM_ERRO);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, FIM_ERRO, "jogada ignorada");
      step(0, 0, 0, 0, 0, FIM_ERRO, "mantem erro");
    end

    // Restart, then no play: timeout 8 cycles after entering espera.
    iniciar_jogo("reinicio apos erro");
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, ESPERA, "espera timer");
    step(0, 0, 0, 0, 0, FIM_TIMEOUT, "timeout");
    step(0, 1, 0, 0, 0, FIM_TIMEOUT, "mantem timeout");

    // Play in the final timer cycle wins; next espera gets a fresh window.
    iniciar_jogo("inicio limite");
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, ESPERA, "espera limite");
    step(0, 1, 0, 0, 0, REGISTRA, "jogada ultimo ciclo");
    step(0, 0, 0, 0, 0, COMPARA, "compara limite");
    step(0, 0, 1, 0, 0, PROXIMA_JOGADA, "decisao limite");
    step(0, 0, 0, 0, 0, ESPERA, "espera nova janela");
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, ESPERA, "janela nova");
    step(0, 0, 0, 0, 0, FIM_TIMEOUT, "timeout janela nova");

    // Reset held across an edge while in compara.
    iniciar_jogo("inicio reset compara");
    step(0, 1, 0, 0, 0, REGISTRA, "registra pre reset");
    step(0, 0, 0, 0, 0, COMPARA, "compara pre reset");
    reset_async("reset em compara", 1'b1);
    step(0, 0, 0, 0, 0, INICIAL, "pos reset compara");
    step(1, 0, 0, 0, 0, PREPARACAO, "zera tudo");
    step(0, 0, 0, 0, 0, INICIA_RODADA, "zera E");
    step(0, 0, 0, 0, 0, ESPERA, "espera pos reset");

    // Short reset pulse between edges while in espera.
    reset_async("reset entre bordas", 1'b0);
    step(0, 0, 0, 0, 0, INICIAL, "pos reset pulso");
    step(1, 0, 0, 0, 0, PREPARACAO, "zera tudo 2");
    step(0, 0, 0, 0, 0, INICIA_RODADA, "zera E 2");

    repeat (3) @(posedge clock);
    #2;
    check("fila vazia", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=expired want=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/controle_rodadas.md
Name: controle_rodadas

Overview:
- Round-based sequencer for the sequence-memory game datapath (address counter E, limit counter L, play register R, compare logic).
- Round N requires the player to repeat memory positions 0..N.
- On a correct full round, L advances; the game ends on the first wrong play, on a timeout, or after the last round.
- Sits beside fluxo_dados in the next top level and replaces the single-round controller; the play timeout counter is owned here rather than in the datapath.

Parameters:
- TIMEOUT_CICLOS, 5000, clock cycles allowed in espera before timeout (5 s at 1 kHz); minimum 2.
- TW, $clog2(TIMEOUT_CICLOS), timeout counter width.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces state inicial
- iniciar  in  1  start/restart request, level sampled per cycle
- jogada  in  1  one-cycle pulse from datapath: a button press was detected
- botoesIgualMemoria  in  1  registered play equals memory[E]
- enderecoIgualLimite  in  1  E == L
- fimL  in  1  L is at its last value (final round)
- zeraE, contaE  out  1  clear / increment address counter
- zeraL, contaL  out  1  clear / increment limit counter
- zeraR, registraR  out  1  clear / load play register
- acertou, errou, pronto  out  1  game result flags
- timeout  out  1  game ended by timeout
- db_estado  out  4  state code for hex display

Behaviour:
- Moore FSM. All outputs decode from the state register, so they are glitch-free and valid one cycle after each transition.
- Reset: state = inicial (0x0), timeout counter = 0, all control and result outputs 0.
- States, codes and transitions:
  - inicial 0x0: no outputs. iniciar -> preparacao.
  - preparacao 0x1: zeraE, zeraL, zeraR. -> inicia_rodada.
  - inicia_rodada 0x2: zeraE. -> espera.
  - espera 0x3: timer increments each cycle.
    - jogada -> registra.
    - Otherwise, timer == TIMEOUT_CICLOS-1 -> fim_timeout.
    - jogada in the final timer cycle wins over timeout.
  - registra 0x4: registraR. -> compara.
  - compara 0x5:
    - !igual -> fim_erro.
    - igual & enderecoIgualLimite & fimL -> fim_acerto.
    - igual & enderecoIgualLimite & !fimL -> proxima_rodada.
    - igual & !enderecoIgualLimite -> proxima_jogada.
  - proxima_jogada 0x6: contaE. -> espera.
  - proxima_rodada 0x7: contaL. -> inicia_rodada.
  - fim_acerto 0xA: pronto, acertou.
  - fim_erro 0xE: pronto, errou.
  - fim_timeout 0xD: pronto, errou, timeout.
  - All three end states hold until iniciar, then -> preparacao.
- Timer rules:
  - Cleared in every state except espera, so each play gets a full window.
  - Never wraps: the terminal count forces an exit from espera.
- iniciar is ignored in every state except inicial and the end states. A held iniciar in an end state restarts immediately, one game per edge not required.
- jogada outside espera is ignored and not queued.
- Reset asserted mid-round: immediate return to inicial. The datapath is not cleared until the next preparacao.
- Unused state codes go to inicial on the next clock.
- Latency:
  - jogada pulse to compara decision: 2 cycles (espera -> registra -> compara).
  - Correct non-final play back to espera: 3 cycles.

Decomposition:
- Shared package: state code constants (INICIAL..FIM_TIMEOUT, 4-bit), also used by the top level and the display-decoding bench.
- One sub-module, contador_timeout: synchronous clear and enable, TW-bit, with a terminal-count output. It is parameterised by TIMEOUT_CICLOS and reusable by later experiments.
- The FSM next-state and output decode stay in controle_rodadas.

Test Plan:
- TIMEOUT_CICLOS=8, 4-entry memory model, reset then iniciar; correct plays for rounds 0..3 with fimL at L=3 -> contaL pulses 3 times, ends in 0xA with pronto=1, acertou=1, errou=0.
- Round 1, second play wrong (botoesIgualMemoria=0 in compara) -> fim_erro 0xE: errou=1, acertou=0, timeout=0, and no contaE/contaL after the error.
- No jogada for 8 cycles in espera -> fim_timeout 0xD exactly 8 cycles after entering espera; timeout=1, errou=1, pronto=1.
- jogada exactly in timer cycle 7 -> registra (0x4), not 0xD. Next espera visit waits a fresh 8 cycles.
- reset pulsed while in compara, and separately asynchronously between clock edges -> db_estado=0x0 and all outputs 0 immediately. iniciar afterwards produces zeraE, zeraL and zeraR for one cycle.
- In fim_erro, jogada pulses are ignored (state stays 0xE). iniciar -> preparacao 0x1 then inicia_rodada 0x2, and results clear.
